// File: rtl/addsub_serial_pkg.sv
// Shared types for the serial add/sub: FSM states, mode encoding, counter sizing.
// No logic; imported by the interface, the chunk adder and the top.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Start/done bundle for addsub_serial: the requester drives operands and start,
// the adder returns busy, done, result and flags.
interface addsub_serial_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             start;
  logic             m;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, m, x, y,
    input  busy, done, s, carryout, overflow, zero
  );

  modport slave (
    input  start, m, x, y,
    output busy, done, s, carryout, overflow, zero
  );
endinterface

// File: rtl/addsub_serial_chunk.sv
// Purpose: CHUNK-bit ripple adder built from full-adder cells.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Purpose: serial two's-complement add/sub, CHUNK bits per cycle LSB first; flags via ADDSUB_SERIAL_FLAGS_EN.
// Latency: WIDTH/CHUNK cycles from the accepting edge to the one-cycle done pulse.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input logic           clk,
  input logic           rst,
  addsub_serial_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  localparam int PW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_upd;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    pos;
  logic [CHUNK-1:0] sum_chunk;
  logic             chunk_cout;
  logic             chunk_msb_c;
  logic             accept;
  logic             last;

  assign accept = (state != RUN) && bus.start;
  assign last   = (cnt_q == CW'(N - 1));
  assign pos    = PW'(int'(cnt_q) * CHUNK);

  addsub_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a        (a_q[pos +: CHUNK]),
    .b        (b_q[pos +: CHUNK]),
    .cin      (carry_q),
    .sum      (sum_chunk),
    .cout     (chunk_cout),
    .c_msb_in (chunk_msb_c)
  );

  // Result with the current chunk merged in; on the last chunk this is the final sum.
  always_comb begin
    s_upd                = s_q;
    s_upd[pos +: CHUNK]  = sum_chunk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // Subtract is x + ~y + 1: invert y on capture and seed the carry with the mode bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.x;
      b_q     <= bus.y ^ {WIDTH{bus.m == MODE_SUB}};
      carry_q <= (bus.m == MODE_SUB);
      cnt_q   <= '0;
    end else if (state == RUN) begin
      s_q     <= s_upd;
      carry_q <= chunk_cout;
      cnt_q   <= last ? '0 : cnt_q + 1'b1;
      if (last) begin
        cout_q <= chunk_cout;
      end
    end
  end

  assign bus.s        = s_q;
  assign bus.carryout = cout_q;

`ifdef ADDSUB_SERIAL_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if ((state == RUN) && last) begin
      ovf_q  <= chunk_msb_c ^ chunk_cout;
      zero_q <= (s_upd == '0);
    end
  end

  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
`else
  logic flags_unused;

  assign flags_unused = chunk_msb_c;
  assign bus.overflow = 1'b0;
  assign bus.zero     = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: one instance at CHUNK=1 and one at CHUNK=4 share the same stimulus.
module tb_addsub_serial;

  localparam int W  = 8;
  localparam int N1 = 8;
  localparam int N4 = 2;
`ifdef ADDSUB_SERIAL_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   free1 = 0;
  int   free4 = 0;
  exp_t q1[$];
  exp_t q4[$];

  addsub_serial_if #(.WIDTH(W)) b1 ();
  addsub_serial_if #(.WIDTH(W)) b4 ();

  addsub_serial #(.WIDTH(W), .CHUNK(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  addsub_serial #(.WIDTH(W), .CHUNK(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic mm, input logic [7:0] xx, input logic [7:0] yy, input int due);
    exp_t e;
    int   sx;
    int   sy;
    int   r;
    sx = int'($signed(xx));
    sy = int'($signed(yy));
    if (mm) begin
      e.s = xx - yy;
      e.c = (xx >= yy);
      r   = sx - sy;
    end else begin
      e.s = xx + yy;
      e.c = (int'(xx) + int'(yy)) > 255;
      r   = sx + sy;
    end
    e.v   = FLAGS && (r > 127 || r < -128);
    e.z   = FLAGS && (e.s == 8'h00);
    e.due = due;
    return e;
  endfunction

  // Called just after a falling edge; a start is taken at the next rising edge if that DUT is free.
  task automatic apply(input logic st, input logic mm, input logic [7:0] xx, input logic [7:0] yy);
    b1.start = st; b1.m = mm; b1.x = xx; b1.y = yy;
    b4.start = st; b4.m = mm; b4.x = xx; b4.y = yy;
    if (st && !rst) begin
      if (cyc >= free1) begin
        q1.push_back(model(mm, xx, yy, cyc + 1 + N1));
        free1 = cyc + 1 + N1;
      end
      if (cyc >= free4) begin
        q4.push_back(model(mm, xx, yy, cyc + 1 + N4));
        free4 = cyc + 1 + N4;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q1.size() > 0 || q4.size() > 0) && n < 40) begin
      @(negedge clk);
      apply(1'b0, 1'b0, 8'h00, 8'h00);
      n++;
    end
    check({name, "_drain_left"}, q1.size() + q4.size(), 0);
  endtask

  task automatic run_op(input logic mm, input logic [7:0] xx, input logic [7:0] yy);
    @(negedge clk);
    apply(1'b1, mm, xx, yy);
    drain("op");
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_done;
    check("busy1", b1.busy, (cyc >= free1 - N1) && (cyc < free1));
    check("busy4", b4.busy, (cyc >= free4 - N4) && (cyc < free4));
    exp_done = (q1.size() > 0) && (q1[0].due == cyc);
    check("done1", b1.done, exp_done);
    if (exp_done) begin
      e = q1.pop_front();
      check("s1", b1.s, e.s);
      check("carryout1", b1.carryout, e.c);
      check("overflow1", b1.overflow, e.v);
      check("zero1", b1.zero, e.z);
    end
    exp_done = (q4.size() > 0) && (q4[0].due == cyc);
    check("done4", b4.done, exp_done);
    if (exp_done) begin
      e = q4.pop_front();
      check("s4", b4.s, e.s);
      check("carryout4", b4.carryout, e.c);
      check("overflow4", b4.overflow, e.v);
      check("zero4", b4.zero, e.z);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       dm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] dx [6] = '{8'h05, 8'h05, 8'h03, 8'h7F, 8'hFF, 8'h80};
    logic [7:0] dy [6] = '{8'h03, 8'h03, 8'h05, 8'h01, 8'h01, 8'h01};
    bit         hit;

    apply(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_busy", b1.busy, 0);
    check("rst_done", b1.done, 0);
    check("rst_s", b1.s, 0);
    check("rst_carryout", b1.carryout, 0);
    check("rst_overflow", b1.overflow, 0);
    check("rst_zero", b1.zero, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(dm[i], dx[i], dy[i]);

    // Second start lands in the third RUN cycle of the CHUNK=1 instance and must be ignored there.
    @(negedge clk); apply(1'b1, 1'b0, 8'h12, 8'h34);
    repeat (2) begin @(negedge clk); apply(1'b0, 1'b0, 8'h00, 8'h00); end
    @(negedge clk); apply(1'b1, 1'b1, 8'hAA, 8'h55);
    @(negedge clk); apply(1'b0, 1'b0, 8'h00, 8'h00);
    drain("ignore");

    // Start raised exactly in the done cycle: next result must follow N+1 cycles later.
    @(negedge clk); apply(1'b1, 1'b0, 8'h40, 8'h41);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (cyc == free1) begin
        apply(1'b1, 1'b1, 8'h10, 8'h20);
        hit = 1'b1;
      end else begin
        apply(1'b0, 1'b0, 8'h00, 8'h00);
      end
    end
    @(negedge clk); apply(1'b0, 1'b0, 8'h00, 8'h00);
    drain("b2b");

    run_op(1'b1, 8'h05, 8'h03);
    @(negedge clk); apply(1'b1, 1'b0, 8'hFF, 8'hFF);
    repeat (4) begin @(negedge clk); apply(1'b0, 1'b0, 8'h00, 8'h00); end
    #2 rst = 1'b1;
    free1 = 0;
    free4 = 0;
    q1.delete();
    q4.delete();
    #1;
    check("arst_busy", b1.busy, 0);
    check("arst_done", b1.done, 0);
    check("arst_s", b1.s, 0);
    check("arst_carryout", b1.carryout, 0);
    check("arst_overflow", b1.overflow, 0);
    check("arst_zero", b1.zero, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin @(negedge clk); apply(1'b0, 1'b0, 8'h00, 8'h00); end
    run_op(1'b0, 8'h21, 8'h13);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      apply(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    @(negedge clk); apply(1'b0, 1'b0, 8'h00, 8'h00);
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle two's-complement adder/subtractor with start/done handshake. It processes WIDTH-bit operands CHUNK bits per clock, LSB first, and reports carry/borrow plus optional signed-overflow and zero flags. It is the sequential successor to the team's 4-bit ripple add/sub. It sits in the lab datapath wherever area matters more than single-cycle latency.

## Interface
- WIDTH, 8: operand and result width in bits; ≥2.
- CHUNK, 1: bits processed per cycle; must divide WIDTH. N = WIDTH/CHUNK cycles per operation.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only when not busy
- m  input  1  mode: 0 = add (x+y), 1 = subtract (x−y)
- x  input  WIDTH  operand A, captured on accepted start
- y  input  WIDTH  operand B, captured on accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result valid
- s  output  WIDTH  result; held until the next accepted start
- carryout  output  1  carry out of MSB (subtract: 1 = no borrow, x ≥ y unsigned)
- overflow  output  1  signed overflow
- zero  output  1  s == 0

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- IDLE or DONE with start=1:
  - capture x and y XOR {WIDTH{m}};
  - set the carry register to m and the chunk counter to 0;
  - go to RUN.
- RUN, each cycle:
  - add chunk [CHUNK·k +: CHUNK] of both operand registers plus the carry register;
  - store the CHUNK-bit sum into s at the same position and update the carry;
  - increment k.
- Leaving RUN: when k == N−1, the next state is DONE.
- DONE:
  - done=1 for exactly one cycle;
  - carryout, overflow and zero are updated on the edge entering DONE;
  - next state is IDLE, or RUN if start=1.
- start while in RUN is ignored. x, y and m may change freely during RUN with no effect.
- Flags:
  - overflow = carry into MSB XOR carry out of MSB;
  - zero = (s == 0).
- Reset while busy aborts the operation. All registers clear and no done pulse is produced.
- Reset values: busy=0, done=0, s=0, carryout=0, overflow=0, zero=0, counter=0, state IDLE.

## Timing
- Start is accepted on rising edge T. busy=1 from after T until after edge T+N. done=1 during the cycle following edge T+N.
- Latency is N cycles from the accepting edge to done. For WIDTH=8, CHUNK=1 that is 8 cycles; for CHUNK=4 it is 2 cycles.
- Back-to-back: start high in the DONE cycle is accepted. Throughput is one result per N+1 cycles.
- During RUN, s is partially updated. s is valid only from done onward.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- ADDSUB_SERIAL_FLAGS_EN:
  - defined: overflow and zero are computed and registered as described;
  - undefined: the overflow and zero ports still exist but are tied to 0, and their logic and registers are not built.
- carryout, s, busy and done are identical in both builds.

## Structure
- Shared package addsub_pkg:
  - state enum {IDLE, RUN, DONE};
  - mode constants MODE_ADD=0 and MODE_SUB=1;
  - a function returning the counter width, $clog2(N) with a minimum of 1.
- One sub-module, addsub_chunk: a CHUNK-bit ripple adder of full-adder cells.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb_in (carry into its top bit, used for overflow).
- The top level holds the FSM, counter, operand registers and flag logic.

## Test plan
All cases use WIDTH=8 and CHUNK=1 unless stated.
- m=0, x=0x05, y=0x03 → after 8 cycles done pulses; s=0x08, carryout=0, overflow=0, zero=0.
- m=1, x=0x05, y=0x03 → s=0x02, carryout=1. Then m=1, x=0x03, y=0x05 → s=0xFE, carryout=0, overflow=0.
- m=0, x=0x7F, y=0x01 → s=0x80, overflow=1. Then m=0, x=0xFF, y=0x01 → s=0x00, carryout=1, zero=1.
- start pulsed again in cycle 3 of RUN with different operands → ignored; the original result is delivered after 8 cycles. Start held in the DONE cycle → second operation begins with no idle cycle.
- rst asserted mid-RUN (cycle 4) → busy, done, s and flags read 0 immediately (asynchronous clear). No done pulse follows. The next start runs normally.
- CHUNK=4, m=1, x=0x80, y=0x01 → done 2 cycles after the accepting edge; s=0x7F, overflow=1. With ADDSUB_SERIAL_FLAGS_EN undefined → overflow and zero stay 0.
